tank_motion_ctrl: RTL and testbench

TANK_MOTION_CTRL -- requirements
Module: tank_motion_ctrl

---
 rtl/tank_motion_ctrl_if.sv | 26 ++
 rtl/tank_motion_ctrl.sv | 136 +++++++++++++
 tb/tb_tank_motion_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tank_motion_ctrl_if.sv
// Bundles the tank motion controller's frame/request inputs, the
// collision-checker handshake and the committed-position outputs.
interface tank_motion_if;
    logic       frame_tick;
    logic       Move_Req;
    logic [1:0] Move_Dir;
    logic [8:0] Next_X;
    logic [8:0] Next_Y;
    logic       Next_Collide;
    logic [8:0] Tank_X;
    logic [8:0] Tank_Y;
    logic [1:0] Tank_Dir;
    logic       Moved;
    logic       Blocked;
    logic       Busy;

    modport slave (
        input  frame_tick, Move_Req, Move_Dir, Next_Collide,
        output Next_X, Next_Y, Tank_X, Tank_Y, Tank_Dir, Moved, Blocked, Busy
    );

    modport master (
        output frame_tick, Move_Req, Move_Dir, Next_Collide,
        input  Next_X, Next_Y, Tank_X, Tank_Y, Tank_Dir, Moved, Blocked, Busy
    );
endinterface

// File: rtl/tank_motion_ctrl.sv
// Per-frame tank mover: IDLE -> PROPOSE -> CHECK, commits or rejects one STEP move.
// Define TANK_GRID_ALIGN_EN to snap the perpendicular coordinate to 8 pixels on turns.
module tank_motion_ctrl #(
    parameter logic [8:0] START_X = 9'd128,
    parameter logic [8:0] START_Y = 9'd208,
    parameter logic [8:0] STEP    = 9'd1
) (
    input logic          Clk,
    input logic          Reset_n,
    tank_motion_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROPOSE = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] tank_x_q, tank_x_d;
    logic [8:0] tank_y_q, tank_y_d;
    logic [8:0] next_x_q, next_x_d;
    logic [8:0] next_y_q, next_y_d;
    logic [1:0] dir_q, dir_d;
    logic       moved_q, moved_d;
    logic       blocked_q, blocked_d;
    logic       accept;
`ifdef TANK_GRID_ALIGN_EN
    logic       turn_q, turn_d;

    // Nearest multiple of 8, ties rounding up, modulo 512.
    function automatic logic [8:0] snap8(input logic [8:0] v);
        logic [8:0] t;
        t = v + 9'd4;
        return {t[8:3], 3'b000};
    endfunction
`endif

    assign accept = (state_q == IDLE) && bus.frame_tick && bus.Move_Req;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            tank_x_q  <= START_X;
            tank_y_q  <= START_Y;
            next_x_q  <= START_X;
            next_y_q  <= START_Y;
            dir_q     <= 2'd0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
`ifdef TANK_GRID_ALIGN_EN
            turn_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tank_x_q  <= tank_x_d;
            tank_y_q  <= tank_y_d;
            next_x_q  <= next_x_d;
            next_y_q  <= next_y_d;
            dir_q     <= dir_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
`ifdef TANK_GRID_ALIGN_EN
            turn_q    <= turn_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PROPOSE;
            PROPOSE: state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tank_x_d  = tank_x_q;
        tank_y_d  = tank_y_q;
        next_x_d  = next_x_q;
        next_y_d  = next_y_q;
        dir_d     = dir_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
`ifdef TANK_GRID_ALIGN_EN
        turn_d    = turn_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d = bus.Move_Dir;
`ifdef TANK_GRID_ALIGN_EN
                    // Axis parity differs -> the new heading is perpendicular.
                    turn_d = bus.Move_Dir[0] ^ dir_q[0];
`endif
                end
            end
            PROPOSE: begin
                next_x_d = tank_x_q;
                next_y_d = tank_y_q;
                case (dir_q)
                    2'd0:    next_y_d = tank_y_q - STEP;
                    2'd1:    next_x_d = tank_x_q + STEP;
                    2'd2:    next_y_d = tank_y_q + STEP;
                    default: next_x_d = tank_x_q - STEP;
                endcase
`ifdef TANK_GRID_ALIGN_EN
                if (turn_q) begin
                    if (dir_q[0]) next_y_d = snap8(tank_y_q);
                    else          next_x_d = snap8(tank_x_q);
                end
`endif
            end
            CHECK: begin
                if (bus.Next_Collide) begin
                    blocked_d = 1'b1;
                end else begin
                    tank_x_d = next_x_q;
                    tank_y_d = next_y_q;
                    moved_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.Next_X   = next_x_q;
    assign bus.Next_Y   = next_y_q;
    assign bus.Tank_X   = tank_x_q;
    assign bus.Tank_Y   = tank_y_q;
    assign bus.Tank_Dir = dir_q;
    assign bus.Moved    = moved_q;
    assign bus.Blocked  = blocked_q;
    assign bus.Busy     = (state_q != IDLE);
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Bench for tank_motion_ctrl: directed scenarios plus a randomized run, checked
// every cycle against a transaction-level model of the tank's motion.
module tb_tank_motion_ctrl;
    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    logic force_blk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    tank_motion_if bus();

    tank_motion_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial forever #5 Clk = ~Clk;

    // Boundary checker: playfield is 0..272 in both axes, plus an obstacle flag.
    always_comb bus.Next_Collide = (bus.Next_X > 9'd272) || (bus.Next_Y > 9'd272) || force_blk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a move accepted at edge a shows its heading after a, its
    // candidate after a+1 and its verdict/commit after a+2.
    int m_x = 128, m_y = 208, m_dir = 0, m_nx = 128, m_ny = 208;
    int m_moved = 0, m_blocked = 0;
    bit pend = 0;
    int acc_n = 0, cyc = 0, cand_x = 0, cand_y = 0;

    function automatic int snap(input int v);
        return ((v + 4) / 8 * 8) % 512;
    endfunction

    function automatic void model_reset();
        m_x = 128; m_y = 208; m_dir = 0; m_nx = 128; m_ny = 208;
        m_moved = 0; m_blocked = 0; pend = 0;
    endfunction

    function automatic void model_edge();
        int prev;
        m_moved   = 0;
        m_blocked = 0;
        if (pend) begin
            if (cyc == acc_n + 1) begin
                m_nx = cand_x;
                m_ny = cand_y;
            end else if (cyc == acc_n + 2) begin
                if (cand_x > 272 || cand_y > 272 || force_blk) m_blocked = 1;
                else begin
                    m_x = cand_x;
                    m_y = cand_y;
                    m_moved = 1;
                end
                pend = 0;
            end
        end else if (bus.frame_tick && bus.Move_Req) begin
            prev   = m_dir;
            m_dir  = int'(bus.Move_Dir);
            pend   = 1;
            acc_n  = cyc;
            cand_x = m_x;
            cand_y = m_y;
            case (m_dir)
                0: cand_y = (m_y + 512 - 1) % 512;
                1: cand_x = (m_x + 1) % 512;
                2: cand_y = (m_y + 1) % 512;
                default: cand_x = (m_x + 512 - 1) % 512;
            endcase
`ifdef TANK_GRID_ALIGN_EN
            if ((m_dir % 2) != (prev % 2)) begin
                if (m_dir % 2 == 0) cand_x = snap(m_x);
                else                cand_y = snap(m_y);
            end
`endif
        end
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) model_reset();
        else begin
            cyc++;
            model_edge();
        end
        #1;
        chk("tank_x",   int'(bus.Tank_X),   m_x);
        chk("tank_y",   int'(bus.Tank_Y),   m_y);
        chk("tank_dir", int'(bus.Tank_Dir), m_dir);
        chk("next_x",   int'(bus.Next_X),   m_nx);
        chk("next_y",   int'(bus.Next_Y),   m_ny);
        chk("moved",    int'(bus.Moved),    m_moved);
        chk("blocked",  int'(bus.Blocked),  m_blocked);
        chk("busy",     int'(bus.Busy),     int'(pend));
        chk("excl",     int'(bus.Moved && bus.Blocked), 0);
    end

    int cap_nx, cap_ny, busy_seen;

    task automatic do_move(input int d, input bit f, input bit dbl);
        @(negedge Clk);
        bus.frame_tick = 1'b1;
        bus.Move_Req   = 1'b1;
        bus.Move_Dir   = 2'(d);
        force_blk      = f;
        @(negedge Clk);
        bus.frame_tick = dbl;
        busy_seen      = int'(bus.Busy);
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        bus.Move_Req   = 1'b0;
        cap_nx         = int'(bus.Next_X);
        cap_ny         = int'(bus.Next_Y);
        @(negedge Clk);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.Move_Req   = 1'b0;
        bus.Move_Dir   = 2'd0;
        repeat (3) @(negedge Clk);
        chk("rst_x",    int'(bus.Tank_X), 128);
        chk("rst_y",    int'(bus.Tank_Y), 208);
        chk("rst_dir",  int'(bus.Tank_Dir), 0);
        chk("rst_nx",   int'(bus.Next_X), 128);
        chk("rst_ny",   int'(bus.Next_Y), 208);
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_pulse", int'(bus.Moved) + int'(bus.Blocked), 0);
        Reset_n = 1'b1;

        // Single right move from reset.
        do_move(1, 1'b0, 1'b0);
        chk("m1_busy", busy_seen, 1);
        chk("m1_nx", cap_nx, 129);
        chk("m1_x", int'(bus.Tank_X), 129);
        chk("m1_y", int'(bus.Tank_Y), 208);
        chk("m1_moved", int'(bus.Moved), 1);
        chk("m1_blocked", int'(bus.Blocked), 0);

        // Extra frame_tick during PROPOSE is dropped, not queued.
        do_move(1, 1'b0, 1'b1);
        chk("dbl_x", int'(bus.Tank_X), 130);
        chk("dbl_moved", int'(bus.Moved), 1);
        @(negedge Clk);
        chk("dbl_moved_off", int'(bus.Moved), 0);
        chk("dbl_no_queue", int'(bus.Busy), 0);

        // Build Tank_X=133, Tank_Y=100 facing right using blocked turns.
        for (int i = 0; i < 3; i++) do_move(1, 1'b0, 1'b0);
        chk("x133", int'(bus.Tank_X), 133);
        do_move(0, 1'b1, 1'b0);
        chk("turn_blk", int'(bus.Blocked), 1);
        chk("turn_dir", int'(bus.Tank_Dir), 0);
        chk("turn_x", int'(bus.Tank_X), 133);
        for (int i = 0; i < 300 && bus.Tank_Y != 9'd100; i++) do_move(0, 1'b0, 1'b0);
        chk("y100", int'(bus.Tank_Y), 100);
        do_move(1, 1'b1, 1'b0);
        chk("face_r", int'(bus.Tank_Dir), 1);
        chk("face_r_y", int'(bus.Tank_Y), 100);
        do_move(0, 1'b0, 1'b0);
`ifdef TANK_GRID_ALIGN_EN
        chk("grid_nx", cap_nx, 136);
        chk("grid_x",  int'(bus.Tank_X), 136);
`else
        chk("grid_nx", cap_nx, 133);
        chk("grid_x",  int'(bus.Tank_X), 133);
`endif
        chk("grid_ny", cap_ny, 99);
        chk("grid_y",  int'(bus.Tank_Y), 99);

        // Up from Y=0 wraps to 511 and is rejected.
        for (int i = 0; i < 300 && bus.Tank_Y != 9'd0; i++) do_move(0, 1'b0, 1'b0);
        chk("y0", int'(bus.Tank_Y), 0);
        do_move(0, 1'b0, 1'b0);
        chk("wrap_ny", cap_ny, 511);
        chk("wrap_y", int'(bus.Tank_Y), 0);
        chk("wrap_blk", int'(bus.Blocked), 1);
        chk("wrap_moved", int'(bus.Moved), 0);

        // Obstacle at X=256 facing right.
        for (int i = 0; i < 300 && bus.Tank_X != 9'd256; i++) do_move(1, 1'b0, 1'b0);
        chk("x256", int'(bus.Tank_X), 256);
        do_move(1, 1'b1, 1'b0);
        chk("obs_x", int'(bus.Tank_X), 256);
        chk("obs_dir", int'(bus.Tank_Dir), 1);
        chk("obs_blk", int'(bus.Blocked), 1);

        // Reset during CHECK aborts the move immediately.
        @(negedge Clk);
        bus.frame_tick = 1'b1;
        bus.Move_Req   = 1'b1;
        bus.Move_Dir   = 2'd2;
        force_blk      = 1'b0;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_x", int'(bus.Tank_X), 128);
        chk("abort_y", int'(bus.Tank_Y), 208);
        chk("abort_busy", int'(bus.Busy), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        bus.Move_Req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("abort_pulse", int'(bus.Moved) + int'(bus.Blocked), 0);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.Move_Req   = ($urandom_range(0, 3) != 0);
            bus.Move_Dir   = 2'($urandom_range(0, 3));
            force_blk      = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 Reset_n = 1'b0;
                #1 chk("rnd_rst_x", int'(bus.Tank_X), 128);
                @(negedge Clk);
                Reset_n = 1'b1;
            end
        end
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
